// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: drives the input interface of a 3x3 convolution
// layer through one frame (PRELOAD, raster of SHIFTs with a LOAD between
// output rows), tracks the current output window and flags protocol errors
// and ack timeouts.
module conv_layer_sequencer #(
  parameter int OUT_ROWS = 6,
  parameter int OUT_COLS = 6,
  parameter int TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       err_clr,
  input  logic [1:0] ack,
  output logic [1:0] cmd,
  output logic       iface_en,
  output logic       busy,
  output logic       pix_valid,
  output logic [2:0] row_idx,
  output logic [2:0] col_idx,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE_REQ,
    S_PRE_WAIT,
    S_SHF_REQ,
    S_SHF_WAIT,
    S_LD_REQ,
    S_LD_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_SHIFT   = 2'd2;
  localparam logic [1:0] CMD_LOAD    = 2'd3;

  localparam logic [1:0] ACK_IDLE = 2'd0;
  localparam logic [1:0] ACK_PRE  = 2'd1;
  localparam logic [1:0] ACK_SHF  = 2'd2;
  localparam logic [1:0] ACK_LD   = 2'd3;

  localparam logic [2:0] LAST_ROW  = 3'(OUT_ROWS - 1);
  localparam logic [2:0] LAST_COL  = 3'(OUT_COLS - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] row_nxt;
  logic [2:0] col_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       timed_out;

  // The last permitted wait cycle: without the expected ack now, the wait
  // has lasted TIMEOUT cycles and the frame is abandoned.
  assign timed_out = (wait_cnt == WAIT_LAST);

  // Window completion is reported in the same cycle as the SHIFT ack, while
  // the indices still point at the finished window; abort suppresses it.
  assign pix_valid = (state == S_SHF_WAIT) && (ack == ACK_SHF) && !abort;

  function automatic logic [1:0] cmd_of(input state_t s);
    case (s)
      S_PRE_REQ: cmd_of = CMD_PRELOAD;
      S_SHF_REQ: cmd_of = CMD_SHIFT;
      S_LD_REQ:  cmd_of = CMD_LOAD;
      default:   cmd_of = CMD_IDLE;
    endcase
  endfunction

  // Next-state, window-index and wait-counter logic; error state only
  // leaves on err_clr, everywhere else abort wins over all other inputs.
  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    col_nxt   = col_idx;
    wait_nxt  = wait_cnt;
    if (state == S_ERR) begin
      if (err_clr) state_nxt = S_IDLE;
    end else if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_PRE_REQ;
            row_nxt   = 3'd0;
            col_nxt   = 3'd0;
          end
        end
        S_PRE_REQ: begin
          state_nxt = S_PRE_WAIT;
          wait_nxt  = 8'd0;
        end
        S_SHF_REQ: begin
          state_nxt = S_SHF_WAIT;
          wait_nxt  = 8'd0;
        end
        S_LD_REQ: begin
          state_nxt = S_LD_WAIT;
          wait_nxt  = 8'd0;
        end
        S_PRE_WAIT: begin
          if (ack == ACK_PRE) state_nxt = S_SHF_REQ;
          else if (ack != ACK_IDLE || timed_out) state_nxt = S_ERR;
          else wait_nxt = wait_cnt + 8'd1;
        end
        S_SHF_WAIT: begin
          if (ack == ACK_SHF) begin
            if (col_idx < LAST_COL) begin
              col_nxt   = col_idx + 3'd1;
              state_nxt = S_SHF_REQ;
            end else if (row_idx < LAST_ROW) begin
              col_nxt   = 3'd0;
              state_nxt = S_LD_REQ;
            end else begin
              state_nxt = S_DONE;
            end
          end else if (ack != ACK_IDLE || timed_out) begin
            state_nxt = S_ERR;
          end else begin
            wait_nxt = wait_cnt + 8'd1;
          end
        end
        S_LD_WAIT: begin
          if (ack == ACK_LD) begin
            row_nxt   = row_idx + 3'd1;
            state_nxt = S_SHF_REQ;
          end else if (ack != ACK_IDLE || timed_out) begin
            state_nxt = S_ERR;
          end else begin
            wait_nxt = wait_cnt + 8'd1;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register with outputs decoded from the next state so that every
  // output is a flop aligned with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      row_idx  <= 3'd0;
      col_idx  <= 3'd0;
      wait_cnt <= 8'd0;
      cmd      <= CMD_IDLE;
      iface_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      row_idx  <= row_nxt;
      col_idx  <= col_nxt;
      wait_cnt <= wait_nxt;
      cmd      <= cmd_of(state_nxt);
      iface_en <= (state_nxt != S_IDLE) && (state_nxt != S_ERR);
      busy     <= (state_nxt != S_IDLE) && (state_nxt != S_ERR);
      done     <= (state_nxt == S_DONE);
      err      <= (state_nxt == S_ERR);
    end
  end

endmodule
